// File: rtl/permutation_xor.sv
// ASCON round datapath: optional pre-round data/key injection, one full ASCON
// round, optional post-round key/domain injection, and the 320-bit state register.

package ascon_pack;
    // S[0]..S[4], each a 64-bit lane of the ASCON state
    typedef logic [4:0][63:0] type_state;
endpackage

module permutation_xor
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        select_i,
    input  type_state   permutation_i,
    input  logic [3:0]  round_i,
    input  logic        enable_i,
    input  logic [127:0] xor_key_i,
    input  logic [63:0] xor_data_i,
    input  logic [1:0]  etat_up_i,
    input  logic [1:0]  etat_down_i,
    output type_state   permutation_o
);

    type_state  state_q;
    type_state  state_d;
    type_state  muxState;
    type_state  preXorState;
    type_state  constState;
    type_state  sboxState;
    type_state  linState;
    logic [3:0] constHigh;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign muxState  = select_i ? permutation_i : state_q;
    assign constHigh = 4'hF - round_i;

    always_comb begin
        preXorState = muxState;
        if (etat_up_i[0]) begin
            preXorState[0] = muxState[0] ^ xor_data_i;
        end
        if (etat_up_i[1]) begin
            preXorState[1] = muxState[1] ^ xor_key_i[127:64];
            preXorState[2] = muxState[2] ^ xor_key_i[63:0];
        end
    end

    always_comb begin
        constState       = preXorState;
        constState[2]    = preXorState[2] ^ {56'h0, constHigh, round_i};
    end

    // Bit-sliced S-box: every 64-bit word operation evaluates all 64 columns at once.
    always_comb begin
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = constState[0];
        x1 = constState[1];
        x2 = constState[2];
        x3 = constState[3];
        x4 = constState[4];

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        sboxState[0] = x0;
        sboxState[1] = x1;
        sboxState[2] = x2;
        sboxState[3] = x3;
        sboxState[4] = x4;
    end

    always_comb begin
        linState[0] = sboxState[0] ^ rotr(sboxState[0], 19) ^ rotr(sboxState[0], 28);
        linState[1] = sboxState[1] ^ rotr(sboxState[1], 61) ^ rotr(sboxState[1], 39);
        linState[2] = sboxState[2] ^ rotr(sboxState[2], 1)  ^ rotr(sboxState[2], 6);
        linState[3] = sboxState[3] ^ rotr(sboxState[3], 10) ^ rotr(sboxState[3], 17);
        linState[4] = sboxState[4] ^ rotr(sboxState[4], 7)  ^ rotr(sboxState[4], 41);
    end

    // Key and domain-separation bits both land on S4, so apply them sequentially.
    always_comb begin
        state_d = linState;
        if (etat_down_i[0]) begin
            state_d[3] = state_d[3] ^ xor_key_i[127:64];
            state_d[4] = state_d[4] ^ xor_key_i[63:0];
        end
        if (etat_down_i[1]) begin
            state_d[4] = state_d[4] ^ 64'h1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            state_q <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
        end
    end

    assign permutation_o = state_q;

endmodule

// File: tb/tb_permutation_xor.sv
// Self-checking bench for permutation_xor: directed ASCON round/pb/hold/reset steps
// followed by randomized traffic, all compared against a table-driven round model.

module tb_permutation_xor;
    import ascon_pack::*;

    logic        clock;
    logic        resetb;
    logic        sel;
    type_state   perm;
    logic [3:0]  rnd;
    logic        en;
    logic [127:0] key;
    logic [63:0] data;
    logic [1:0]  up;
    logic [1:0]  down;
    type_state   permOut;

    type_state   expState;
    int          checks;
    int          failures;

    logic [4:0] sboxTable [0:31] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };
    int rotA [0:4] = '{19, 61, 1, 10, 7};
    int rotB [0:4] = '{28, 39, 6, 17, 41};

    permutation_xor dut (
        .clock_i      (clock),
        .resetb_i     (resetb),
        .select_i     (sel),
        .permutation_i(perm),
        .round_i      (rnd),
        .enable_i     (en),
        .xor_key_i    (key),
        .xor_data_i   (data),
        .etat_up_i    (up),
        .etat_down_i  (down),
        .permutation_o(permOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One ASCON round from its textbook definition: table S-box per column.
    function automatic type_state modelRound(input type_state x, input logic [3:0] r,
                                             input logic [1:0] u, input logic [1:0] d,
                                             input logic [127:0] k, input logic [63:0] dt);
        type_state  s;
        type_state  t;
        logic [4:0] idx;
        logic [4:0] v;
        int         c;
        s = x;
        if (u[0]) s[0] = s[0] ^ dt;
        if (u[1]) begin
            s[1] = s[1] ^ k[127:64];
            s[2] = s[2] ^ k[63:0];
        end
        c = ((15 - int'(r)) & 15) * 16 + int'(r);
        s[2][7:0] = s[2][7:0] ^ c[7:0];
        for (int j = 0; j < 64; j++) begin
            idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            v = sboxTable[idx];
            t[0][j] = v[4];
            t[1][j] = v[3];
            t[2][j] = v[2];
            t[3][j] = v[1];
            t[4][j] = v[0];
        end
        for (int i = 0; i < 5; i++) begin
            s[i] = t[i] ^ ror(t[i], rotA[i]) ^ ror(t[i], rotB[i]);
        end
        if (d[0]) begin
            s[3] = s[3] ^ k[127:64];
            s[4] = s[4] ^ k[63:0];
        end
        if (d[1]) s[4] = s[4] ^ 64'h1;
        return s;
    endfunction

    function automatic type_state randState();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic applyStimulus(input logic r, input logic sl, input logic e,
                                 input type_state p, input logic [3:0] rn,
                                 input logic [1:0] u, input logic [1:0] d,
                                 input logic [127:0] k, input logic [63:0] dt);
        type_state src;
        resetb = r;
        sel    = sl;
        en     = e;
        perm   = p;
        rnd    = rn;
        up     = u;
        down   = d;
        key    = k;
        data   = dt;
        src = sl ? p : expState;
        if (r) expState = '0;
        else if (e) expState = modelRound(src, rn, u, d, k, dt);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (permOut === expState) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, permOut, expState);
            $error("[TB] comparison %s did not hold", tag);
        end
    endtask

    initial begin
        type_state    vecState;
        type_state    heldState;
        logic [127:0] vecKey;
        logic [63:0]  vecData;
        checks   = 0;
        failures = 0;
        expState = '0;

        // reset with enable high and arbitrary inputs
        applyStimulus(1'b1, 1'b1, 1'b1, randState(), 4'd3, 2'b11, 2'b11,
                      {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        checkOutput("reset");

        vecKey  = 128'h000102030405060708090A0B0C0D0E0F;
        vecData = 64'h3230323380000000;
        vecState[0] = 64'h1b1354db77e0dbb4;
        vecState[1] = 64'h6f140401cfa0873c;
        vecState[2] = 64'hd7e8abaf45f2885a;
        vecState[3] = 64'hc0c5777fa661625e;
        vecState[4] = 64'hfc4374d28210928c;
        applyStimulus(1'b0, 1'b1, 1'b1, vecState, 4'd6, 2'b01, 2'b00, vecKey, vecData);
        checkOutput("single_round");

        for (int r = 7; r <= 11; r++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, randState(), 4'(r), 2'b00,
                          (r == 11) ? 2'b01 : 2'b00, vecKey, vecData);
            checkOutput($sformatf("pb_round%0d", r));
        end

        heldState = expState;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b0, randState(), 4'($urandom),
                          2'($urandom), 2'($urandom),
                          {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            checkOutput($sformatf("hold%0d", i));
        end
        checks++;
        assert (permOut === heldState) else begin
            failures++;
            $display("[TB] FAIL hold_final observed=%h expected=%h", permOut, heldState);
            $error("[TB] comparison hold_final did not hold");
        end

        applyStimulus(1'b0, 1'b1, 1'b1, '0, 4'd0, 2'b00, 2'b00, vecKey, vecData);
        checkOutput("const_round0");
        applyStimulus(1'b0, 1'b1, 1'b1, '0, 4'd11, 2'b00, 2'b00, vecKey, vecData);
        checkOutput("const_round11");

        applyStimulus(1'b0, 1'b1, 1'b1, randState(), 4'($urandom_range(0, 11)), 2'b11, 2'b10,
                      {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        checkOutput("mixed_xor");

        applyStimulus(1'b0, 1'b0, 1'b1, randState(), 4'd4, 2'b00, 2'b00, vecKey, vecData);
        checkOutput("mid_seq_round");
        applyStimulus(1'b1, 1'b0, 1'b1, randState(), 4'd5, 2'b11, 2'b11, vecKey, vecData);
        checkOutput("mid_seq_reset");
        applyStimulus(1'b0, 1'b1, 1'b1, vecState, 4'd0, 2'b10, 2'b00, vecKey, vecData);
        checkOutput("reload_after_reset");

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) != 0), randState(),
                          4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom),
                          {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            checkOutput($sformatf("random%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
